// File: rtl/mux4_arb_pkg.sv
// Shared types and the round-robin pick helper for the 4:1 arbitrated mux.
package mux4_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned DATA_W  = 32;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic pick_t rr_pick(req_vec_t req, sel_t ptr);
        pick_t p;
        sel_t  idx;
        p.found = 1'b0;
        p.idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr + sel_t'(k);
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain combinational 4:1 word mux used as the arbiter datapath.
module mux_4_1 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] d0_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    input  logic [DATA_W-1:0] d3_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        unique case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with registered 4:1 output stage.
// Optional per-requester grant counters enabled by MUX4_ARB_PERF_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned DATA_W = mux4_arb_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        req_valid_i,
    output logic [3:0]        req_ready_o,
    input  logic [DATA_W-1:0] input_0,
    input  logic [DATA_W-1:0] input_1,
    input  logic [DATA_W-1:0] input_2,
    input  logic [DATA_W-1:0] input_3,
    output logic [1:0]        sel_o,
    output logic              valid_o,
    input  logic              ready_i,
`ifdef MUX4_ARB_PERF_EN
    input  logic              cnt_clr_i,
    output logic [4*16-1:0]   grant_cnt_o,
`endif
    output logic [DATA_W-1:0] data_o
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    sel_t              sel_q, sel_d;
    sel_t              ptr_q, ptr_d;

    pick_t             pick;
    logic              can_load;
    logic              hs;
    logic [DATA_W-1:0] mux_y;

    assign pick     = rr_pick(req_valid_i, ptr_q);
    assign can_load = (state_q == EMPTY) || ready_i;
    // Ready is held low while reset is asserted, even though the state already reads EMPTY.
    assign hs       = can_load && pick.found && !rst_i;
    assign req_ready_o = hs ? req_vec_t'(4'b0001 << pick.idx) : '0;

    mux_4_1 #(.DATA_W(DATA_W)) u_mux (
        .sel_i (pick.idx),
        .d0_i  (input_0),
        .d1_i  (input_1),
        .d2_i  (input_2),
        .d3_i  (input_3),
        .y_o   (mux_y)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (hs) begin
            state_d = FULL;
            data_d  = mux_y;
            sel_d   = pick.idx;
            ptr_d   = pick.idx + sel_t'(1);
        end else if (state_q == FULL && ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o = (state_q == FULL);
    assign data_o  = data_q;
    assign sel_o   = sel_q;

`ifdef MUX4_ARB_PERF_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    // Clear wins over a same-cycle grant; counts stick at all-ones.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr_i) begin
                cnt_d[i] = '0;
            end else if (hs && pick.idx == sel_t'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign grant_cnt_o = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
